// File: rtl/fwrisc_imem_resp_if.sv
// rtl/fwrisc_imem_resp_if.sv - fwrisc instruction-fetch handshake bundle
interface fwrisc_imem_resp_if;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] idata;
    logic        iready;
    logic        buf_hit;
    logic        inval;

    // Fetch stage side: issues requests and buffer invalidations
    modport master (
        output iaddr,
        output ivalid,
        output inval,
        input  idata,
        input  iready,
        input  buf_hit
    );

    // Responder side
    modport slave (
        input  iaddr,
        input  ivalid,
        input  inval,
        output idata,
        output iready,
        output buf_hit
    );
endinterface

// File: rtl/fwrisc_imem_resp.sv
// rtl/fwrisc_imem_resp.sv - instruction fetch responder with wait states and last-fetch buffer
module fwrisc_imem_resp #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 0,
    parameter int BUF_EN      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    fwrisc_imem_resp_if.slave    fetch,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Counter load value: WAIT lasts WAIT_STATES cycles, the last one issues the read
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_BITS-1:0]  buf_tag_q, buf_tag_d;
    logic [31:0]           buf_data_q, buf_data_d;
    logic [31:0]           idata_q, idata_d;
    logic                  iready_q, iready_d;
    logic                  buf_hit_q, buf_hit_d;

    logic [ADDR_BITS-1:0]  req_word;
    logic                  hit;

    assign req_word = fetch.iaddr[ADDR_BITS+1:2];

    // A concurrent invalidate always defeats the buffer so stale code is never returned
    assign hit = (BUF_EN != 0) && buf_valid_q && (buf_tag_q == req_word) && !fetch.inval;

    assign fetch.idata   = idata_q;
    assign fetch.iready  = iready_q;
    assign fetch.buf_hit = buf_hit_q;

    // Next-state, datapath and SRAM strobe decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        idata_d     = idata_q;
        iready_d    = 1'b0;
        buf_hit_d   = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = addr_q;

        case (state_q)
            S_IDLE: begin
                mem_addr = req_word;
                if (fetch.inval) begin
                    buf_valid_d = 1'b0;
                end
                if (fetch.ivalid) begin
                    addr_d = req_word;
                    pend_d = fetch.inval;
                    if (hit) begin
                        idata_d   = buf_data_q;
                        iready_d  = 1'b1;
                        buf_hit_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (WAIT_STATES == 0) begin
                        mem_rd  = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        cnt_d   = WS_INIT;
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (fetch.inval) begin
                    buf_valid_d = 1'b0;
                    pend_d      = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    mem_rd  = 1'b1;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DATA: begin
                idata_d     = mem_rdata;
                buf_data_d  = mem_rdata;
                buf_tag_d   = addr_q;
                // Word read may predate a store into imem; only trust it if no inval arrived
                buf_valid_d = !(pend_q || fetch.inval);
                iready_d    = 1'b1;
                state_d     = S_RESP;
            end

            S_RESP: begin
                if (fetch.inval) begin
                    buf_valid_d = 1'b0;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= 32'd0;
            idata_q     <= 32'd0;
            iready_q    <= 1'b0;
            buf_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            idata_q     <= idata_d;
            iready_q    <= iready_d;
            buf_hit_q   <= buf_hit_d;
        end
    end

endmodule

// File: tb/tb_fwrisc_imem_resp.sv
// tb/tb_fwrisc_imem_resp.sv - self-checking bench for fwrisc_imem_resp
module tb_fwrisc_imem_resp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    fwrisc_imem_resp_if f0 ();
    fwrisc_imem_resp_if f1 ();

    logic [11:0] mem_addr0, mem_addr1;
    logic        mem_rd0, mem_rd1;
    logic [31:0] rdata0, rdata1;

    logic [31:0] mem [0:4095];

    int errors = 0;
    int checks = 0;
    int nfetch [2];
    int irdy_cnt [2];
    bit ref_valid [2];
    logic [11:0] ref_tag [2];
    bit last_keep = 1'b0;

    fwrisc_imem_resp #(.ADDR_BITS(12), .WAIT_STATES(0), .BUF_EN(1)) u0 (
        .clock(clock), .reset(reset), .fetch(f0.slave),
        .mem_addr(mem_addr0), .mem_rd(mem_rd0), .mem_rdata(rdata0)
    );

    fwrisc_imem_resp #(.ADDR_BITS(12), .WAIT_STATES(3), .BUF_EN(1)) u1 (
        .clock(clock), .reset(reset), .fetch(f1.slave),
        .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_rdata(rdata1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rd0) rdata0 <= mem[mem_addr0];
        if (mem_rd1) rdata1 <= mem[mem_addr1];
    end

    always @(posedge clock) begin
        if (f0.iready) irdy_cnt[0] = irdy_cnt[0] + 1;
        if (f1.iready) irdy_cnt[1] = irdy_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [31:0] a, input logic inv);
        if (k == 0) begin
            f0.ivalid = v; f0.iaddr = a; f0.inval = inv;
        end else begin
            f1.ivalid = v; f1.iaddr = a; f1.inval = inv;
        end
    endtask

    task automatic set_inval(input int k, input logic inv);
        if (k == 0) f0.inval = inv;
        else        f1.inval = inv;
    endtask

    task automatic sample(input int k, output logic rdy, output logic hit, output logic [31:0] d,
                          output logic rd, output logic [11:0] ma);
        if (k == 0) begin
            rdy = f0.iready; hit = f0.buf_hit; d = f0.idata; rd = mem_rd0; ma = mem_addr0;
        end else begin
            rdy = f1.iready; hit = f1.buf_hit; d = f1.idata; rd = mem_rd1; ma = mem_addr1;
        end
    endtask

    // One fetch; inv_cycle = cycle offset from acceptance carrying inval (-1: none).
    // keep leaves ivalid high for a back-to-back request.
    task automatic fetch(input int k, input logic [31:0] addr, input int inv_cycle, input bit keep);
        logic [11:0] word;
        int ws, exp_lat, got, rd_n, rd_cnt;
        bit exp_hit, inv_applied;
        logic rdy, hit, rd;
        logic [31:0] d;
        logic [11:0] ma, rd_ma;

        word    = addr[13:2];
        ws      = (k == 0) ? 0 : 3;
        exp_hit = ref_valid[k] && (ref_tag[k] == word) && (inv_cycle != 0);
        exp_lat = exp_hit ? 1 : 2 + ws;
        inv_applied = (inv_cycle == 0);

        drive(k, 1'b1, addr, inv_cycle == 0);
        if (last_keep) @(negedge clock);
        #1;
        sample(k, rdy, hit, d, rd, ma);
        rd_n = -1; rd_cnt = 0; rd_ma = '0;
        if (rd) begin
            rd_cnt = 1; rd_n = 0; rd_ma = ma;
        end
        got = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            sample(k, rdy, hit, d, rd, ma);
            if (rd) begin
                rd_cnt++;
                if (rd_n < 0) begin
                    rd_n = n; rd_ma = ma;
                end
            end
            if (rdy) begin
                got = n;
                break;
            end
            set_inval(k, n == inv_cycle);
            if (n == inv_cycle) inv_applied = 1'b1;
        end
        set_inval(k, 1'b0);

        check($sformatf("latency k%0d a%h", k, addr), got, exp_lat);
        check($sformatf("idata k%0d a%h", k, addr), d, mem[word]);
        check($sformatf("buf_hit k%0d a%h", k, addr), {31'd0, hit}, {31'd0, exp_hit});
        check($sformatf("mem_rd count k%0d a%h", k, addr), rd_cnt, exp_hit ? 0 : 1);
        if (!exp_hit) begin
            check($sformatf("mem_rd cycle k%0d a%h", k, addr), rd_n, ws);
            check($sformatf("mem_addr k%0d a%h", k, addr), {20'd0, rd_ma}, {20'd0, word});
        end

        if (inv_applied) begin
            ref_valid[k] = 1'b0;
        end else if (!exp_hit) begin
            ref_valid[k] = 1'b1;
            ref_tag[k]   = word;
        end
        nfetch[k]++;

        last_keep = keep;
        if (!keep) begin
            drive(k, 1'b0, addr, 1'b0);
            @(negedge clock);
            sample(k, rdy, hit, d, rd, ma);
            check($sformatf("iready single pulse k%0d a%h", k, addr), {31'd0, rdy}, 32'd0);
        end
    endtask

    // Start a miss, then reset the design in cycle abort_n after acceptance
    task automatic abort(input int k, input logic [31:0] addr, input int abort_n);
        logic rdy, hit, rd;
        logic [31:0] d;
        logic [11:0] ma;
        drive(k, 1'b1, addr, 1'b0);
        for (int n = 1; n <= abort_n; n++) begin
            @(negedge clock);
            sample(k, rdy, hit, d, rd, ma);
            check($sformatf("no early iready k%0d n%0d", k, n), {31'd0, rdy}, 32'd0);
        end
        reset = 1'b1;
        drive(k, 1'b0, addr, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        sample(k, rdy, hit, d, rd, ma);
        check($sformatf("abort iready k%0d", k), {31'd0, rdy}, 32'd0);
        check($sformatf("abort idata k%0d", k), d, 32'd0);
        for (int n = 0; n < 6; n++) @(negedge clock);
        ref_valid[0] = 1'b0;
        ref_valid[1] = 1'b0;
        last_keep = 1'b0;
    endtask

    initial begin
        logic rdy, hit, rd;
        logic [31:0] d;
        logic [11:0] ma;
        logic [31:0] a;
        int k, inv;
        bit keep;

        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[1] = 32'h0050_0093;
        nfetch[0] = 0; nfetch[1] = 0;
        irdy_cnt[0] = 0; irdy_cnt[1] = 0;
        ref_valid[0] = 1'b0; ref_valid[1] = 1'b0;
        ref_tag[0] = '0; ref_tag[1] = '0;
        drive(0, 1'b0, 32'd0, 1'b0);
        drive(1, 1'b0, 32'd0, 1'b0);

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int kk = 0; kk < 2; kk++) begin
            sample(kk, rdy, hit, d, rd, ma);
            check($sformatf("reset iready k%0d", kk), {31'd0, rdy}, 32'd0);
            check($sformatf("reset buf_hit k%0d", kk), {31'd0, hit}, 32'd0);
            check($sformatf("reset idata k%0d", kk), d, 32'd0);
            check($sformatf("reset mem_rd k%0d", kk), {31'd0, rd}, 32'd0);
        end

        // Directed sequence on the zero-wait-state responder
        fetch(0, 32'h4, -1, 0);
        fetch(0, 32'h4, -1, 0);
        fetch(0, 32'h6, -1, 0);
        fetch(0, 32'h4, -1, 1);
        fetch(0, 32'h8, -1, 0);
        fetch(0, 32'h8 | 32'h4000, -1, 0);
        fetch(0, 32'h8, 0, 0);
        fetch(0, 32'h8, -1, 0);
        fetch(0, 32'hC, 1, 0);
        fetch(0, 32'hC, -1, 0);

        // Directed sequence on the three-wait-state responder
        fetch(1, 32'h4, -1, 0);
        fetch(1, 32'h4, -1, 0);
        fetch(1, 32'h10, 2, 0);
        fetch(1, 32'h10, -1, 0);

        // Reset in DATA and in WAIT, then first fetches must miss
        fetch(0, 32'h4, -1, 0);
        abort(0, 32'h20, 1);
        abort(1, 32'h24, 2);
        abort(1, 32'h28, 4);
        fetch(0, 32'h4, -1, 0);
        fetch(1, 32'h4, -1, 0);

        // Randomized fetch mix over a small working set, with aliasing and invalidates
        for (int i = 0; i < 60; i++) begin
            k = last_keep ? k : int'($urandom % 2);
            a = {($urandom % 4 == 0) ? 18'($urandom) : 18'd0, 12'($urandom % 8), 2'($urandom)};
            inv = ($urandom % 5 == 0) ? int'($urandom_range(0, (k == 0) ? 1 : 4)) : -1;
            keep = ($urandom % 4 == 0) && (i != 59);
            fetch(k, a, inv, keep);
        end

        repeat (4) @(negedge clock);
        check("iready total k0", irdy_cnt[0], nfetch[0]);
        check("iready total k1", irdy_cnt[1], nfetch[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
